// File: rtl/fifo_generator.sv
//------------------------------------------------------------------------------
// Module   : fifo_generator
// Brief    : Single-clock FIFO with registered full/empty/almost flags.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_generator #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic              almost_empty
);

    localparam logic [ADDR_W:0] c_DEPTH    = ADDR_W'(DEPTH) == '0 ? {1'b1, {ADDR_W{1'b0}}}
                                                              : (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_DEPTH_M1 = c_DEPTH - 1'b1;
    localparam logic [ADDR_W:0] c_ONE      = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic [DATA_W-1:0] dout_q,   dout_d;
    logic              full_q,   full_d;
    logic              afull_q,  afull_d;
    logic              empty_q,  empty_d;
    logic              aempty_q, aempty_d;

    logic w_wr_acc;
    logic w_rd_acc;

    // Acceptance uses the registered flags, i.e. the state before the edge.
    assign w_wr_acc = wr_en && !full_q;
    assign w_rd_acc = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;

        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem_q[rd_ptr_q];
        end

        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + c_ONE;
            2'b01:   count_d = count_q - c_ONE;
            default: count_d = count_q;
        endcase

        full_d   = (count_d == c_DEPTH);
        afull_d  = (count_d >= c_DEPTH_M1);
        empty_d  = (count_d == '0);
        aempty_d = (count_d <= c_ONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
        end
    end

    // Storage is left unreset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout         = dout_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_generator.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo_generator
// Brief    : Directed scoreboard bench for fifo_generator.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] dout;
    logic       full;
    logic       almost_full;
    logic       empty;
    logic       almost_empty;

    int         checks   = 0;
    int         failures = 0;

    logic [7:0] sb_q [$];
    int         mdl_cnt  = 0;
    logic [7:0] exp_dout = 8'h00;

    fifo_generator #(
        .DATA_W(8),
        .DEPTH (16),
        .ADDR_W(4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty),
        .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/full"},         32'(full),         32'(mdl_cnt == 16));
        chk({tag, "/almost_full"},  32'(almost_full),  32'(mdl_cnt >= 15));
        chk({tag, "/empty"},        32'(empty),        32'(mdl_cnt == 0));
        chk({tag, "/almost_empty"}, 32'(almost_empty), 32'(mdl_cnt <= 1));
        chk({tag, "/dout"},         32'(dout),         32'(exp_dout));
    endtask

    // One clock: drive while clk is low, update the model at the edge, compare on negedge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input string tag);
        bit wa;
        bit ra;
        wr_en = w;
        din   = d;
        rd_en = r;
        wa = w && (mdl_cnt < 16);
        ra = r && (mdl_cnt > 0);
        @(posedge clk);
        if (ra) exp_dout = sb_q.pop_front();
        if (wa) sb_q.push_back(d);
        mdl_cnt = mdl_cnt + int'(wa) - int'(ra);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        int  sent;
        int  got;
        bit  saw_full;
        logic sw;
        logic sr;
        bit  sra;
        bit  swa;

        rst   = 1'b1;
        din   = 8'h00;
        wr_en = 1'b0;
        rd_en = 1'b0;

        // 1. reset held for 5 cycles
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_outputs("reset_release");

        // 2. fill 0x00..0x0F then an ignored write while full
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, "fill");
        cyc(1'b1, 8'hAA, 1'b0, "write_when_full");

        // 3. drain, then an ignored read while empty
        for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, "drain");
        chk("drain_last", 32'(dout), 32'h0F);
        cyc(1'b0, 8'h00, 1'b1, "read_when_empty");

        // 4a. simultaneous at count=5
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0, "t4_fill5");
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b1, "t4_simul5");
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, "t4_drain5");
        // 4b. simultaneous when full
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0, "t4_fill16");
        cyc(1'b1, 8'hEE, 1'b1, "t4_simul_full");
        chk("t4_full_to15_af", 32'(almost_full), 32'd1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1, "t4_drain15");
        // 4c. simultaneous when empty
        cyc(1'b1, 8'h77, 1'b1, "t4_simul_empty");
        chk("t4_empty_dout_hold", 32'(dout), 32'h4F);
        cyc(1'b0, 8'h00, 1'b1, "t4_read77");

        // 5. flow-controlled streaming across several pointer wraps
        sent     = 0;
        got      = 0;
        saw_full = 1'b0;
        for (int i = 0; i < 2000 && got < 100; i++) begin
            sw  = (sent < 100) && !almost_full;
            sr  = !almost_empty || (sent >= 100 && !empty);
            swa = sw && (mdl_cnt < 16);
            sra = sr && (mdl_cnt > 0);
            cyc(sw, 8'(sent), sr, "stream");
            if (swa) sent++;
            if (full) saw_full = 1'b1;
            if (sra) begin
                chk("stream_seq", 32'(dout), 32'(8'(got)));
                got++;
            end
        end
        chk("stream_got", 32'(got), 32'd100);
        chk("stream_never_full", 32'(saw_full), 32'd0);

        // 6. asynchronous reset with count=7
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0, "t6_fill7");
        cyc(1'b0, 8'h00, 1'b1, "t6_read1");
        cyc(1'b1, 8'h67, 1'b0, "t6_fill7b");
        #2 rst = 1'b1;
        #1;
        sb_q.delete();
        mdl_cnt  = 0;
        exp_dout = 8'h00;
        check_outputs("t6_async_reset");
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 8'h55, 1'b0, "t6_write55");
        cyc(1'b0, 8'h00, 1'b1, "t6_read55");
        chk("t6_dout55", 32'(dout), 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
